// File: rtl/chase_controller_if.sv
// Bundle between the UI/tracker side and the chase controller.
//   vsync       video vsync (frame tick source)
//   track, move UI enables; the controller is active only while both are high
//   blob_valid  tracker found the goal blob in the last frame
//   cur_pos_x   blob centre x (unsigned, 9 bit)
//   cur_rad     blob radius (unsigned, 7 bit)
//   goal_rad    target radius latched by the UI (unsigned, 7 bit)
//   speed1/2    signed left/right wheel speeds (9 bit)
//   ctrl_state  controller state encoding (debug)
//   lost        high while searching for a lost blob
// master = UI/tracker side, slave = controller side.
interface chase_controller_if;
   logic              vsync;
   logic              track;
   logic              move;
   logic              blob_valid;
   logic [8:0]        cur_pos_x;
   logic [6:0]        cur_rad;
   logic [6:0]        goal_rad;
   logic signed [8:0] speed1;
   logic signed [8:0] speed2;
   logic [2:0]        ctrl_state;
   logic              lost;

   modport master (
      output vsync, track, move, blob_valid, cur_pos_x, cur_rad, goal_rad,
      input  speed1, speed2, ctrl_state, lost
   );

   modport slave (
      input  vsync, track, move, blob_valid, cur_pos_x, cur_rad, goal_rad,
      output speed1, speed2, ctrl_state, lost
   );
endinterface

// File: rtl/chase_controller.sv
// Closed-loop motor scheduler for the chase bot. Once per video frame it
// sequences align/approach/hold/backoff/search from the tracked blob and drives
// slew-limited signed wheel speeds.
//   clk_65mhz  system clock
//   reset_n    asynchronous active-low reset
//   bus        chase_controller_if.slave (UI/tracker inputs, speed/state outputs)
// Pipeline: tick edge updates state and samples inputs, next edge registers the
// raw speeds, the edge after that applies the slew limit to the outputs.
module chase_controller #(
   parameter int unsigned CENTER_X     = 160,
   parameter int unsigned DEADBAND     = 8,
   parameter int unsigned TURN_SHIFT   = 1,
   parameter int unsigned FWD_SHIFT    = 2,
   parameter int unsigned RAD_TOL      = 3,
   parameter int unsigned MAX_SPEED    = 100,
   parameter int unsigned SEARCH_SPEED = 30,
   parameter int unsigned BACK_SPEED   = 40,
   parameter int unsigned SLEW         = 16,
   parameter int unsigned LOST_FRAMES  = 8
) (
   input  logic               clk_65mhz,
   input  logic               reset_n,
   chase_controller_if.slave  bus
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StAlign    = 3'd1;
   localparam logic [2:0] StApproach = 3'd2;
   localparam logic [2:0] StHold     = 3'd3;
   localparam logic [2:0] StBackoff  = 3'd4;
   localparam logic [2:0] StSearch   = 3'd5;

   localparam int unsigned MissW = $clog2(LOST_FRAMES + 1);

   localparam logic signed [7:0]  RadTolS = 8'(RAD_TOL);
   localparam logic signed [10:0] MaxS    = 11'(MAX_SPEED);
   localparam logic signed [10:0] SlewS   = 11'(SLEW);
   localparam logic signed [8:0]  SearchS = 9'(SEARCH_SPEED);
   localparam logic signed [8:0]  BackS   = 9'(BACK_SPEED);

   function automatic logic signed [8:0] sat(input logic signed [10:0] v);
      logic signed [10:0] r;
      r = v;
      if (v > MaxS) r = MaxS;
      else if (v < -MaxS) r = -MaxS;
      return r[8:0];
   endfunction

   function automatic logic signed [8:0] slew(input logic signed [8:0] old,
                                              input logic signed [8:0] raw);
      logic signed [10:0] diff;
      diff = {{2{raw[8]}}, raw} - {{2{old[8]}}, old};
      if (diff > SlewS) diff = SlewS;
      else if (diff < -SlewS) diff = -SlewS;
      return old + diff[8:0];
   endfunction

   function automatic logic [2:0] rad_pick(input logic signed [7:0] rerr);
      if (rerr > RadTolS) return StApproach;
      if (rerr < -RadTolS) return StBackoff;
      return StHold;
   endfunction

   // Frame tick from synchronised vsync
   logic vs_meta_q, vs_sync_q, vs_prev_q;
   logic tick;
   assign tick = vs_sync_q & ~vs_prev_q;

   logic enable;
   assign enable = bus.track & bus.move;

   logic [2:0]        state_q, state_d;
   logic [MissW-1:0]  miss_q, miss_d;
   logic              adv;
   logic              v1_q, v2_q;
   logic [8:0]        x_q;
   logic [6:0]        cur_q, goal_q;
   logic signed [8:0] raw1_q, raw2_q, raw1_d, raw2_d;
   logic signed [8:0] speed1_q, speed2_q;

   // Live error terms for the transition decision at the tick
   logic signed [9:0] err_now;
   logic [9:0]        abs_now;
   logic signed [7:0] rad_now;
   assign err_now = $signed({1'b0, bus.cur_pos_x}) - $signed(10'(CENTER_X));
   assign abs_now = err_now[9] ? 10'(-err_now) : 10'(err_now);
   assign rad_now = $signed({1'b0, bus.goal_rad}) - $signed({1'b0, bus.cur_rad});

   always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      adv     = 1'b0;
      if (!enable) begin
         state_d = StIdle;
         miss_d  = '0;
      end else if (tick) begin
         if (!bus.blob_valid) begin
            if (miss_q != MissW'(LOST_FRAMES)) miss_d = miss_q + MissW'(1);
            // Coasting frames hold everything; once lost, keep slewing toward search
            if (miss_d == MissW'(LOST_FRAMES)) begin
               state_d = StSearch;
               adv     = 1'b1;
            end
         end else begin
            miss_d = '0;
            adv    = 1'b1;
            case (state_q)
               StIdle, StSearch: state_d = StAlign;
               StAlign: begin
                  if (abs_now <= 10'(DEADBAND)) state_d = rad_pick(rad_now);
               end
               StApproach, StHold, StBackoff: begin
                  if (abs_now > 10'(2 * DEADBAND)) state_d = StAlign;
                  else state_d = rad_pick(rad_now);
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   // Raw speed from the sampled frame inputs and the freshly updated state
   logic signed [9:0]  err_s, turn10;
   logic signed [10:0] turn, fwd;
   logic signed [7:0]  rad_s;
   always_comb begin
      err_s  = $signed({1'b0, x_q}) - $signed(10'(CENTER_X));
      turn10 = err_s >>> TURN_SHIFT;
      turn   = {turn10[9], turn10};
      rad_s  = $signed({1'b0, goal_q}) - $signed({1'b0, cur_q});
      fwd    = {{3{rad_s[7]}}, rad_s} <<< FWD_SHIFT;
      if (fwd < 11'sd0) fwd = 11'sd0;
      else if (fwd > MaxS) fwd = MaxS;
      raw1_d = '0;
      raw2_d = '0;
      case (state_q)
         StAlign: begin
            raw1_d = sat(turn);
            raw2_d = sat(-turn);
         end
         StApproach: begin
            raw1_d = sat(fwd + turn);
            raw2_d = sat(fwd - turn);
         end
         StBackoff: begin
            raw1_d = -BackS;
            raw2_d = -BackS;
         end
         StSearch: begin
            raw1_d = SearchS;
            raw2_d = -SearchS;
         end
         default: begin
            raw1_d = '0;
            raw2_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         vs_meta_q <= 1'b0;
         vs_sync_q <= 1'b0;
         vs_prev_q <= 1'b0;
         state_q   <= StIdle;
         miss_q    <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         x_q       <= '0;
         cur_q     <= '0;
         goal_q    <= '0;
         raw1_q    <= '0;
         raw2_q    <= '0;
         speed1_q  <= '0;
         speed2_q  <= '0;
      end else begin
         vs_meta_q <= bus.vsync;
         vs_sync_q <= vs_meta_q;
         vs_prev_q <= vs_sync_q;
         state_q   <= state_d;
         miss_q    <= miss_d;
         v1_q      <= adv;
         v2_q      <= enable & v1_q;
         if (adv) begin
            x_q    <= bus.cur_pos_x;
            cur_q  <= bus.cur_rad;
            goal_q <= bus.goal_rad;
         end
         if (v1_q) begin
            raw1_q <= raw1_d;
            raw2_q <= raw2_d;
         end
         // Disable bypasses the slew limiter
         if (!enable) begin
            speed1_q <= '0;
            speed2_q <= '0;
         end else if (v2_q) begin
            speed1_q <= slew(speed1_q, raw1_q);
            speed2_q <= slew(speed2_q, raw2_q);
         end
      end
   end

   assign bus.speed1     = speed1_q;
   assign bus.speed2     = speed2_q;
   assign bus.ctrl_state = state_q;
   assign bus.lost       = (state_q == StSearch);

endmodule

// File: tb/tb_chase_controller.sv
module tb_chase_controller;
   logic clk_65mhz = 1'b0;
   logic reset_n   = 1'b0;
   always #5 clk_65mhz = ~clk_65mhz;

   chase_controller_if bus ();

   chase_controller dut (
      .clk_65mhz (clk_65mhz),
      .reset_n   (reset_n),
      .bus       (bus.slave)
   );

   typedef struct {
      int s1;
      int s2;
      int st;
      int lost;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_now(input string name, input int s1, input int s2, input int st,
                            input int lo);
      check({name, ".speed1"}, int'(bus.speed1), s1);
      check({name, ".speed2"}, int'(bus.speed2), s2);
      check({name, ".state"}, int'(bus.ctrl_state), st);
      check({name, ".lost"}, int'(bus.lost), lo);
   endtask

   // One frame: set inputs, queue the expected post-frame outputs, pulse vsync.
   task automatic frame(input int x, input int cur, input int goal, input bit valid,
                        input int s1, input int s2, input int st, input int lo);
      exp_t e;
      bus.cur_pos_x  = 9'(x);
      bus.cur_rad    = 7'(cur);
      bus.goal_rad   = 7'(goal);
      bus.blob_valid = valid;
      e.s1 = s1; e.s2 = s2; e.st = st; e.lost = lo;
      sb.push_back(e);
      bus.vsync = 1'b1;
      repeat (3) @(negedge clk_65mhz);
      bus.vsync = 1'b0;
      repeat (7) @(negedge clk_65mhz);
   endtask

   // Monitor: outputs settle within 5 cycles of vsync rising
   initial begin
      exp_t e;
      forever begin
         @(posedge bus.vsync);
         repeat (6) @(negedge clk_65mhz);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: frame output with no expectation queued");
         end else begin
            e = sb.pop_front();
            check("frame.speed1", int'(bus.speed1), e.s1);
            check("frame.speed2", int'(bus.speed2), e.s2);
            check("frame.state", int'(bus.ctrl_state), e.st);
            check("frame.lost", int'(bus.lost), e.lost);
         end
      end
   end

   task automatic drop_move();
      bus.move = 1'b0;
      @(negedge clk_65mhz);
      check_now("drop_move", 0, 0, 0, 0);
      repeat (2) @(negedge clk_65mhz);
      bus.move = 1'b1;
      @(negedge clk_65mhz);
   endtask

   initial begin
      bus.vsync = 0; bus.track = 0; bus.move = 0; bus.blob_valid = 0;
      bus.cur_pos_x = '0; bus.cur_rad = '0; bus.goal_rad = '0;
      repeat (3) @(negedge clk_65mhz);
      check_now("reset", 0, 0, 0, 0);
      reset_n = 1'b1;
      @(negedge clk_65mhz);
      check_now("post_reset", 0, 0, 0, 0);
      bus.track = 1; bus.move = 1;

      // Align: err 40, turn 20
      frame(200, 20, 20, 1, 16, -16, 1, 0);
      frame(200, 20, 20, 1, 20, -20, 1, 0);
      // Approach fwd 80 from 20/-20
      frame(160, 10, 30, 1, 36, -4, 2, 0);
      frame(160, 10, 30, 1, 52, 12, 2, 0);
      frame(160, 10, 30, 1, 68, 28, 2, 0);
      frame(160, 10, 30, 1, 80, 44, 2, 0);
      frame(160, 10, 30, 1, 80, 60, 2, 0);
      frame(160, 10, 30, 1, 80, 76, 2, 0);
      frame(160, 10, 30, 1, 80, 80, 2, 0);
      // Blob lost: coast 7 frames, then search
      for (int i = 0; i < 7; i++) frame(160, 10, 30, 0, 80, 80, 2, 0);
      frame(160, 10, 30, 0, 64, 64, 5, 1);
      frame(160, 10, 30, 0, 48, 48, 5, 1);
      frame(160, 10, 30, 0, 32, 32, 5, 1);
      frame(160, 10, 30, 0, 30, 16, 5, 1);
      frame(160, 10, 30, 0, 30, 0, 5, 1);
      frame(160, 10, 30, 0, 30, -16, 5, 1);
      frame(160, 10, 30, 0, 30, -30, 5, 1);
      frame(160, 20, 20, 1, 14, -14, 1, 0);

      drop_move();
      frame(160, 10, 30, 1, 0, 0, 1, 0);
      frame(160, 10, 30, 1, 16, 16, 2, 0);
      frame(160, 10, 30, 1, 32, 32, 2, 0);
      frame(160, 10, 30, 1, 48, 48, 2, 0);
      frame(160, 10, 30, 1, 64, 64, 2, 0);
      drop_move();
      frame(160, 10, 30, 1, 0, 0, 1, 0);
      frame(160, 10, 30, 1, 16, 16, 2, 0);
      frame(160, 10, 30, 1, 32, 32, 2, 0);
      frame(160, 10, 30, 1, 48, 48, 2, 0);
      frame(160, 10, 30, 1, 64, 64, 2, 0);
      frame(160, 10, 30, 1, 80, 80, 2, 0);
      // fwd clamps to 100, then turn 4 saturates speed1
      frame(160, 10, 60, 1, 96, 96, 2, 0);
      frame(160, 10, 60, 1, 100, 100, 2, 0);
      frame(168, 10, 60, 1, 100, 96, 2, 0);
      // Backoff, hysteresis exit to align, deadband edge into hold, hold at 2*deadband
      frame(160, 40, 20, 1, 84, 80, 4, 0);
      frame(160, 40, 20, 1, 68, 64, 4, 0);
      frame(180, 40, 20, 1, 52, 48, 1, 0);
      frame(168, 20, 20, 1, 36, 32, 3, 0);
      frame(176, 20, 20, 1, 20, 16, 3, 0);
      // Ramp to 48, then asynchronous reset mid-frame
      drop_move();
      frame(160, 10, 30, 1, 0, 0, 1, 0);
      frame(160, 10, 30, 1, 16, 16, 2, 0);
      frame(160, 10, 30, 1, 32, 32, 2, 0);
      frame(160, 10, 30, 1, 48, 48, 2, 0);
      check_now("pre_reset", 48, 48, 2, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_now("async_reset", 0, 0, 0, 0);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
